// File: rtl/dds_pkg.sv
// Shared constants and elaboration-time sine/slope table generation
// for the four-lane direct digital synthesizer.
package dds_pkg;

    localparam int  c_slope_frac_bits   = 7;
    localparam int  c_ampl_backoff_log2 = 12;
    localparam real c_pi = 3.14159265358979323846;

    function automatic longint round_real(input real x);
        if (x >= 0.0) begin
            return longint'($floor(x + 0.5));
        end
        return -longint'($floor(-x + 0.5));
    endfunction

    function automatic longint lut_sample(
        input int i,
        input int size_log2,
        input int sample_bits
    );
        real ampl;
        real ang;
        ampl = real'((longint'(1) << (sample_bits - 1))
                   - (longint'(1) << c_ampl_backoff_log2));
        ang  = c_pi * real'(i) / real'(longint'(1) << size_log2);
        return round_real(ampl * $sin(ang));
    endfunction

    // Packed entry {slope, sample}; slope carries c_slope_frac_bits of fraction.
    function automatic logic [63:0] lut_entry(
        input int i,
        input int size_log2,
        input int sample_bits,
        input int slope_bits
    );
        longint      s0;
        longint      s1;
        longint      sl;
        logic [63:0] smp_mask;
        logic [63:0] slp_mask;
        s0 = lut_sample(i, size_log2, sample_bits);
        s1 = lut_sample(i + 1, size_log2, sample_bits);
        sl = (s1 - s0) * (longint'(1) << c_slope_frac_bits);
        smp_mask = (64'd1 << sample_bits) - 64'd1;
        slp_mask = (64'd1 << slope_bits) - 64'd1;
        return ((64'(sl) & slp_mask) << sample_bits) | (64'(s0) & smp_mask);
    endfunction

endpackage

// File: rtl/dds_lut_dual_read.sv
// Constant half-wave sine ROM with stored slopes and two registered
// read ports sharing one advance enable.
module dds_lut_dual_read
    import dds_pkg::*;
#(
    parameter int g_addr_bits   = 10,
    parameter int g_sample_bits = 18,
    parameter int g_slope_bits  = 18
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  en_i,
    input  logic [g_addr_bits-1:0]                addr_a_i,
    input  logic [g_addr_bits-1:0]                addr_b_i,
    output logic [g_sample_bits+g_slope_bits-1:0] data_a_o,
    output logic [g_sample_bits+g_slope_bits-1:0] data_b_o
);

    localparam int c_entries = 1 << g_addr_bits;
    localparam int c_e       = g_sample_bits + g_slope_bits;

    logic [c_e-1:0] rom [c_entries];
    logic [c_e-1:0] data_a_q;
    logic [c_e-1:0] data_a_d;
    logic [c_e-1:0] data_b_q;
    logic [c_e-1:0] data_b_d;

    for (genvar i = 0; i < c_entries; i++) begin : g_rom
        assign rom[i] = c_e'(lut_entry(i, g_addr_bits, g_sample_bits,
                                       g_slope_bits));
    end

    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (en_i) begin
            data_a_d = rom[addr_a_i];
            data_b_d = rom[addr_b_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/dds_quad_chan.sv
// Four-sample-per-clock DDS: phase accumulator, sine ROM with slopes,
// linear interpolation, 4-stage pipeline gated by dreq_i.
module dds_quad_chan
    import dds_pkg::*;
#(
    parameter int g_lut_size_log2   = 10,
    parameter int g_lut_sample_bits = 18,
    parameter int g_lut_slope_bits  = 18,
    parameter int g_acc_frac_bits   = 32,
    parameter int g_output_bits     = 14
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic [g_lut_size_log2+g_acc_frac_bits+1:0] acc_i,
    input  logic [g_lut_size_log2+g_acc_frac_bits+1:0] tune_i,
    input  logic                                       acc_load_i,
    input  logic                                       tune_load_i,
    input  logic                                       dreq_i,
    output logic signed [g_output_bits-1:0]            y0_o,
    output logic signed [g_output_bits-1:0]            y1_o,
    output logic signed [g_output_bits-1:0]            y2_o,
    output logic signed [g_output_bits-1:0]            y3_o
);

    localparam int c_w     = g_lut_size_log2 + g_acc_frac_bits + 2;
    localparam int c_fw    = g_lut_slope_bits - 1;
    localparam int c_lo    = g_acc_frac_bits + 1 - c_fw;
    localparam int c_pb    = c_w - c_lo;
    localparam int c_e     = g_lut_sample_bits + g_lut_slope_bits;
    localparam int c_pw    = 2 * g_lut_slope_bits;
    localparam int c_shift = g_lut_slope_bits - 1 + c_slope_frac_bits;
    localparam int c_vw    = g_lut_sample_bits + 2;
    localparam int c_os    = g_lut_sample_bits - g_output_bits;

    localparam logic signed [c_vw-1:0] c_ymax =
        c_vw'((1 <<< (g_output_bits - 1)) - 1);
    localparam logic signed [c_vw-1:0] c_ymin =
        c_vw'(-(1 <<< (g_output_bits - 1)));

    logic [c_w-1:0]                  acc_q;
    logic [c_w-1:0]                  acc_d;
    logic [c_w-1:0]                  tune_q;
    logic [c_w-1:0]                  tune_d;
    logic [3:0][c_pb-1:0]            ph_q;
    logic [3:0][c_pb-1:0]            ph_d;
    logic [3:0][c_e-1:0]             ent;
    logic [3:0][g_output_bits-1:0]   y_all;

    // Only {sign, idx, f} of each lane phase survive stage 1.
    always_comb begin
        tune_d = tune_load_i ? tune_i : tune_q;
        acc_d  = acc_q;
        if (acc_load_i) begin
            acc_d = acc_i;
        end else if (dreq_i) begin
            acc_d = acc_q + (tune_q << 2);
        end
        ph_d = ph_q;
        if (dreq_i) begin
            ph_d[0] = c_pb'(acc_q >> c_lo);
            ph_d[1] = c_pb'((acc_q + tune_q) >> c_lo);
            ph_d[2] = c_pb'((acc_q + (tune_q << 1)) >> c_lo);
            ph_d[3] = c_pb'((acc_q + (tune_q << 1) + tune_q) >> c_lo);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q  <= '0;
            tune_q <= '0;
            ph_q   <= '0;
        end else begin
            acc_q  <= acc_d;
            tune_q <= tune_d;
            ph_q   <= ph_d;
        end
    end

    dds_lut_dual_read #(
        .g_addr_bits   (g_lut_size_log2),
        .g_sample_bits (g_lut_sample_bits),
        .g_slope_bits  (g_lut_slope_bits)
    ) lut01 (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (dreq_i),
        .addr_a_i (ph_q[0][c_pb-2 -: g_lut_size_log2]),
        .addr_b_i (ph_q[1][c_pb-2 -: g_lut_size_log2]),
        .data_a_o (ent[0]),
        .data_b_o (ent[1])
    );

    dds_lut_dual_read #(
        .g_addr_bits   (g_lut_size_log2),
        .g_sample_bits (g_lut_sample_bits),
        .g_slope_bits  (g_lut_slope_bits)
    ) lut23 (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (dreq_i),
        .addr_a_i (ph_q[2][c_pb-2 -: g_lut_size_log2]),
        .addr_b_i (ph_q[3][c_pb-2 -: g_lut_size_log2]),
        .data_a_o (ent[2]),
        .data_b_o (ent[3])
    );

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic                                sgn2_q;
        logic                                sgn2_d;
        logic [c_fw-1:0]                     f2_q;
        logic [c_fw-1:0]                     f2_d;
        logic                                sgn3_q;
        logic                                sgn3_d;
        logic signed [g_lut_sample_bits-1:0] smp3_q;
        logic signed [g_lut_sample_bits-1:0] smp3_d;
        logic signed [c_pw-1:0]              prod3_q;
        logic signed [c_pw-1:0]              prod3_d;
        logic signed [g_output_bits-1:0]     y_q;
        logic signed [g_output_bits-1:0]     y_d;
        logic signed [g_lut_sample_bits-1:0] smp2;
        logic signed [g_lut_slope_bits-1:0]  slp2;
        logic signed [c_pw-1:0]              term4;
        logic signed [c_vw-1:0]              v4;
        logic signed [c_vw-1:0]              sh4;

        assign smp2 = ent[k][g_lut_sample_bits-1:0];
        assign slp2 = ent[k][c_e-1 -: g_lut_slope_bits];

        always_comb begin
            sgn2_d  = sgn2_q;
            f2_d    = f2_q;
            sgn3_d  = sgn3_q;
            smp3_d  = smp3_q;
            prod3_d = prod3_q;
            y_d     = y_q;
            term4   = prod3_q >>> c_shift;
            v4      = c_vw'(smp3_q) + c_vw'(term4);
            if (sgn3_q) begin
                v4 = -v4;
            end
            sh4 = v4 >>> c_os;
            if (dreq_i) begin
                sgn2_d  = ph_q[k][c_pb-1];
                f2_d    = ph_q[k][c_fw-1:0];
                sgn3_d  = sgn2_q;
                smp3_d  = smp2;
                prod3_d = c_pw'(slp2) * c_pw'($signed({1'b0, f2_q}));
                if (sh4 > c_ymax) begin
                    y_d = g_output_bits'(c_ymax);
                end else if (sh4 < c_ymin) begin
                    y_d = g_output_bits'(c_ymin);
                end else begin
                    y_d = g_output_bits'(sh4);
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                sgn2_q  <= 1'b0;
                f2_q    <= '0;
                sgn3_q  <= 1'b0;
                smp3_q  <= '0;
                prod3_q <= '0;
                y_q     <= '0;
            end else begin
                sgn2_q  <= sgn2_d;
                f2_q    <= f2_d;
                sgn3_q  <= sgn3_d;
                smp3_q  <= smp3_d;
                prod3_q <= prod3_d;
                y_q     <= y_d;
            end
        end

        assign y_all[k] = y_q;
    end

    assign y0_o = y_all[0];
    assign y1_o = y_all[1];
    assign y2_o = y_all[2];
    assign y3_o = y_all[3];

endmodule

// File: tb/tb_dds_quad_chan.sv
// Directed bench for dds_quad_chan with hand-derived sine samples
// at quarter, sixteenth and interpolated phase points.
module tb_dds_quad_chan;

    localparam int c_w = 44;
    localparam logic [c_w-1:0] c_one = 44'd1;

    logic                clk_i       = 1'b0;
    logic                rst_n_i     = 1'b0;
    logic [c_w-1:0]      acc_i       = '0;
    logic [c_w-1:0]      tune_i      = '0;
    logic                acc_load_i  = 1'b0;
    logic                tune_load_i = 1'b0;
    logic                dreq_i      = 1'b0;
    logic signed [13:0]  y0_o;
    logic signed [13:0]  y1_o;
    logic signed [13:0]  y2_o;
    logic signed [13:0]  y3_o;

    int checks = 0;
    int errors = 0;
    int s = 0;

    // 16-point sine period: A=126976 sample values shifted right by 4
    int tbl16 [16] = '{0, 3037, 5611, 7331, 7936, 7331, 5611, 3037,
                       0, -3037, -5612, -7332, -7936, -7332, -5612, -3037};

    always #5 clk_i = ~clk_i;

    dds_quad_chan dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .acc_i       (acc_i),
        .tune_i      (tune_i),
        .acc_load_i  (acc_load_i),
        .tune_load_i (tune_load_i),
        .dreq_i      (dreq_i),
        .y0_o        (y0_o),
        .y1_o        (y1_o),
        .y2_o        (y2_o),
        .y3_o        (y3_o)
    );

    task automatic chk(input string tag, input int lane,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lane %0d got %0d expected %0d",
                   tag, lane, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input int e0, input int e1,
                        input int e2, input int e3);
        chk(tag, 0, y0_o, e0);
        chk(tag, 1, y1_o, e1);
        chk(tag, 2, y2_o, e2);
        chk(tag, 3, y3_o, e3);
    endtask

    task automatic expect_s(input string tag, input int base);
        chk4(tag, tbl16[base % 16], tbl16[(base + 1) % 16],
             tbl16[(base + 2) % 16], tbl16[(base + 3) % 16]);
    endtask

    initial begin
        #1;
        chk4("reset", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        @(negedge clk_i);
        tune_i      = c_one << 42;
        acc_i       = '0;
        tune_load_i = 1'b1;
        acc_load_i  = 1'b1;
        dreq_i      = 1'b1;
        @(negedge clk_i);
        tune_load_i = 1'b0;
        acc_load_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        chk4("latency", 0, 0, 0, 0);
        @(negedge clk_i);
        chk4("quarter", 0, 7936, 0, -7936);
        repeat (3) begin
            @(negedge clk_i);
            chk4("quarter_hold", 0, 7936, 0, -7936);
        end

        tune_i      = c_one << 40;
        acc_i       = '0;
        tune_load_i = 1'b1;
        acc_load_i  = 1'b1;
        @(negedge clk_i);
        tune_load_i = 1'b0;
        acc_load_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        chk4("drain", 0, 7936, 0, -7936);
        @(negedge clk_i);
        s = 0;
        expect_s("sixteenth", s);
        repeat (5) begin
            @(negedge clk_i);
            s = (s + 4) % 16;
            expect_s("sixteenth", s);
        end

        dreq_i = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            expect_s("freeze", s);
        end
        dreq_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            s = (s + 4) % 16;
            expect_s("resume", s);
        end

        acc_i      = c_w'(15) << 40;
        acc_load_i = 1'b1;
        @(negedge clk_i);
        acc_load_i = 1'b0;
        s = (s + 4) % 16;
        expect_s("drain2", s);
        repeat (3) begin
            @(negedge clk_i);
            s = (s + 4) % 16;
            expect_s("drain2", s);
        end
        @(negedge clk_i);
        s = 15;
        expect_s("load_wins", s);
        repeat (4) begin
            @(negedge clk_i);
            s = (s + 4) % 16;
            expect_s("wrap", s);
        end

        dreq_i      = 1'b0;
        acc_i       = c_one << 32;
        tune_i      = c_one << 43;
        acc_load_i  = 1'b1;
        tune_load_i = 1'b1;
        @(negedge clk_i);
        acc_load_i  = 1'b0;
        tune_load_i = 1'b0;
        expect_s("load_no_dreq", s);
        dreq_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk4("interp", 12, -13, 12, -13);
        @(negedge clk_i);
        chk4("interp_hold", 12, -13, 12, -13);

        rst_n_i = 1'b0;
        #1;
        chk4("async_reset", 0, 0, 0, 0);
        chk("acc_clr", 0, dut.acc_q, 0);
        chk("tune_clr", 0, dut.tune_q, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (6) @(negedge clk_i);
        chk4("post_reset", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_quad_chan.md
Name: dds_quad_chan

Overview:
- Direct digital synthesizer producing four consecutive sine samples per clock (y0..y3 = sample times n, n+1, n+2, n+3) for a 4:1 serialized high-rate DAC interface.
- Phase accumulator plus a half-wave sine LUT with stored slopes; output uses linear interpolation.
- Sits between the RF control registers (tune/phase load) and the DAC serializer.

Parameters:
- g_lut_size_log2, 10: log2 of LUT entries (half sine period).
- g_lut_sample_bits, 18: signed LUT sample width.
- g_lut_slope_bits, 18: signed LUT slope width.
- g_acc_frac_bits, 32: accumulator fractional bits.
- g_output_bits, 14: signed output sample width.
- Derived: W = g_lut_size_log2 + g_acc_frac_bits + 2 (44 by default).

Ports:
- clk_i  in  1  system clock (one sample set per cycle).
- rst_n_i  in  1  reset, asynchronous, active-low.
- acc_i  in  W  phase value to load.
- tune_i  in  W  phase increment per output sample.
- acc_load_i  in  1  load accumulator from acc_i.
- tune_load_i  in  1  load tune register from tune_i.
- dreq_i  in  1  advance enable for accumulator and pipeline.
- y0_o, y1_o, y2_o, y3_o  out  g_output_bits each  signed samples n..n+3.

Behaviour:
- Reset (async):
  - acc and tune clear to 0.
  - All pipeline registers and y0..y3 clear to 0.
- tune register: loads tune_i on any clock with tune_load_i=1, independent of dreq_i; the new value is used from the next cycle.
- Accumulator update each clock:
  - acc_load_i=1: acc <= acc_i. This has priority over dreq_i.
  - Otherwise, dreq_i=1: acc <= acc + 4*tune, mod 2^W.
  - Otherwise, acc holds.
- Lane phases: p_k = acc + k*tune, mod 2^W, for k = 0..3.
- Phase decode:
  - sign = p[W-1].
  - idx = next g_lut_size_log2 bits.
  - frac = remaining g_acc_frac_bits+1 bits.
  - Full period is 2^W.
- LUT contents:
  - Entry i = {slope_i, sample_i}.
  - sample_i = round(A*sin(pi*i/2^g_lut_size_log2)), with A = 2^(g_lut_sample_bits-1) - 2^12.
  - slope_i = round((sample(i+1) - sample(i)) * 128). The slope fraction scale is 7 bits.
  - LUT contents are constant and generated at elaboration; there is no write port.
  - Two dual-read copies: lut01 serves lanes 0 and 1, lut23 serves lanes 2 and 3.
- Interpolation:
  - f = top (g_lut_slope_bits-1) bits of frac, unsigned.
  - v = sample + ((slope*f) >>> (g_lut_slope_bits-1+7)).
  - If sign=1, v = -v.
- Output: y = v >>> (g_lut_sample_bits - g_output_bits), arithmetic shift (truncate toward -inf), saturated to the g_output_bits signed range.
- Pipeline has 4 stages, all gated by dreq_i:
  - 1: phase add.
  - 2: LUT read, registered.
  - 3: multiply.
  - 4: add, negate, shift into y_o.
- Latency: 4 dreq-high cycles from an acc value to its samples on y_o. With dreq_i=0 all stages and outputs hold.
- acc_load_i mid-run: the new phase reaches the outputs 4 advancing cycles later; older samples drain normally.
- Wrap-around: modular arithmetic with no discontinuity. Phase 2^W-1 followed by 0 is continuous.
- Output frequency = f_clk*4*tune/2^W per sample stream. Example: tune=1e12, f_clk=125 MHz gives fs=500 MS/s and fout of about 28.4 MHz.

Decomposition:
- Package dds_pkg: constant c_slope_frac_bits=7, constant c_ampl_backoff_log2=12, and a function computing the packed LUT entry for index i.
- Sub-module dds_lut_dual_read: ROM with two registered read ports, instantiated twice (lut01, lut23).
- Lane interpolation is a generate loop in the top level.

Test Plan:
- Reset: rst_n_i=0 mid-operation -> all y_o=0 immediately, acc and tune=0. After release with tune=0, outputs stay 0.
- Load acc=0, tune=2^42, dreq=1 -> after 4 cycles y0..y3 = 0, 7936, 0, -7936, constant every cycle.
- tune=2^40, acc=0 -> y0..y3 follow sin at 16 samples/period. y1 = round-trip of sin(pi/8) = 3036 (±1). The pattern repeats every 4 cycles.
- dreq_i toggled 0 for 5 cycles -> outputs frozen. On resume the sequence continues with no skipped or repeated samples.
- tune=1e12 over 262144 cycles -> sample stream spectral purity >70 dBc SFDR, with |y| ≤ 7936. Phase continuity is checked across accumulator wrap.
- acc_load_i and dreq_i high in the same cycle -> acc = acc_i (load wins). The first loaded-phase samples appear 4 cycles later.
